mem_arbiter_n: RTL and testbench
================================

MEM_ARBITER_N -- requirements
Module: mem_arbiter_n

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requesting caches (2..8).
REQ-002 Parameter LINE_WIDTH, default 256, cacheline data width in bits.
REQ-003 Parameter ADDR_WIDTH, default 32, address width in bits.
REQ-004 Parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority (port 0 highest).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req_read  in  NUM_PORTS  per-port line read request.
REQ-009 req_write  in  NUM_PORTS  per-port line write request.
REQ-010 req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port line address, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line, packed the same way.
REQ-012 req_resp  out  NUM_PORTS  one-hot per-port completion pulse.
REQ-013 req_rdata  out  LINE_WIDTH  read line, broadcast to all ports, valid with req_resp.
REQ-014 mem_read / mem_write  out  1 each  downstream cacheline-adapter request.
REQ-015 mem_addr  out  ADDR_WIDTH; mem_wdata  out  LINE_WIDTH  downstream request payload.
REQ-016 mem_rdata  in  LINE_WIDTH; mem_resp  in  1  downstream read data and completion.
REQ-017 busy  out  1  high in any state other than IDLE; grant_id  out  $clog2(NUM_PORTS) (min 1)  port being served.

Function
REQ-018 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-019 A port is requesting when req_read[k] or req_write[k] is high; if both are high, the transaction is a write.
REQ-020 In IDLE with at least one requester, the arbiter SHALL select a winner, register its id, op, address and wdata, and enter BUSY on the next edge.
REQ-021 Fixed mode: the winner is the lowest-index requester.
REQ-022 Round-robin mode: the winner is the first requester at or after rr_ptr, wrapping modulo NUM_PORTS; on each grant, rr_ptr becomes (winner+1) mod NUM_PORTS.
REQ-023 In BUSY, mem_read or mem_write SHALL be driven from the latched op, and mem_addr/mem_wdata from the latched payload, held stable until mem_resp.
REQ-024 When mem_resp is high in BUSY:
- mem_read and mem_write SHALL drop on the next edge.
- mem_rdata SHALL be captured into req_rdata.
- req_resp[grant_id] SHALL pulse high for exactly one cycle, in RESP.
- The FSM SHALL then return to IDLE.
REQ-025 Latency: request seen in IDLE at cycle 0 gives mem_read/mem_write high at cycle 1; mem_resp at cycle n gives req_resp at cycle n+1 and IDLE at cycle n+2.
REQ-026 No arbitration occurs in RESP, so a requester has one cycle to deassert before being re-granted.
REQ-027 A requester dropping its request during BUSY SHALL NOT abort the transaction; the transaction completes and still pulses req_resp.
REQ-028 Request-line changes on any port during BUSY SHALL NOT alter the downstream payload.
REQ-029 mem_resp outside BUSY SHALL be ignored.
REQ-030 req_rdata SHALL hold its last captured value until the next read completion; write completions SHALL NOT update it.

Reset
REQ-031 On rst, the block SHALL return to IDLE and set rr_ptr=0, grant_id=0, busy=0, req_resp=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0 and req_rdata=0.
REQ-032 rst asserted mid-transaction SHALL abandon the transaction without a req_resp pulse; a mem_resp arriving after reset is ignored per REQ-029.

Verification
REQ-033 Single read: port 1 reads 0x0000_1040, mem_resp after 4 cycles with rdata 0xA5 repeated -> mem_read high cycles 1-4 with mem_addr 0x0000_1040, then req_resp=2'b10 for one cycle with matching req_rdata.
REQ-034 Contention, RR_MODE=1, NUM_PORTS=4, all ports requesting continuously -> grants in order 0,1,2,3,0, one req_resp pulse per grant.
REQ-035 Contention, RR_MODE=0, ports 0 and 2 requesting continuously -> port 0 is granted every time and port 2 is starved; after port 0 drops, port 2 is granted next.
REQ-036 Write with changing inputs: port 0 writes 0x200 with data D1, then changes addr/wdata during BUSY -> mem_addr stays 0x200 and mem_wdata stays D1 until mem_resp; req_rdata is unchanged.
REQ-037 Read and write both high on port 0 -> mem_write is issued and mem_read stays 0.
REQ-038 rst during BUSY followed by a late mem_resp -> outputs at reset values, no req_resp pulse, and the next request is served normally starting from rr_ptr=0.

Source files
------------

// File: rtl/mem_arbiter_n.sv
// N-port cacheline arbiter: picks one requesting cache (round-robin or fixed
// priority), forwards its read/write to a single downstream adapter, returns the completion.
module mem_arbiter_n #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int RR_MODE    = 1,
    localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [LINE_WIDTH-1:0]            mem_wdata,
    input  logic [LINE_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_resp,
    output logic                             busy,
    output logic [GW-1:0]                    grant_id
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                                  state;
    logic [GW-1:0]                           rr_ptr;
    logic [NUM_PORTS-1:0]                    requesting;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    addr_v;
    logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]    wdata_v;
    logic [GW-1:0]                           idx;
    logic [GW-1:0]                           winner;
    logic [GW-1:0]                           next_ptr;
    logic                                    any_req;

    assign requesting = req_read | req_write;
    assign addr_v     = req_addr;
    assign wdata_v    = req_wdata;

    // Scan order starts at rr_ptr in round-robin mode, at port 0 otherwise;
    // the first requester found wins.
    always_comb begin
        idx     = '0;
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = GW'((RR_MODE != 0) ? ((int'(rr_ptr) + i) % NUM_PORTS) : i);
            if (!any_req && requesting[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    assign next_ptr = (int'(winner) == NUM_PORTS - 1) ? '0 : winner + 1'b1;

    // mem_write doubles as the latched op while BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            req_resp  <= '0;
            req_rdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            req_resp <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id  <= winner;
                        rr_ptr    <= next_ptr;
                        mem_write <= req_write[winner];
                        mem_read  <= ~req_write[winner];
                        mem_addr  <= addr_v[winner];
                        mem_wdata <= wdata_v[winner];
                        busy      <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        if (!mem_write)
                            req_rdata <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        req_resp  <= NUM_PORTS'(1) << grant_id;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Randomized scoreboard bench for mem_arbiter_n: a round-robin instance driven by a
// transaction-level reference model, plus a fixed-priority instance for starvation.
module tb_mem_arbiter_n;
    localparam int N  = 4;
    localparam int LW = 64;
    localparam int AW = 32;
    localparam int GW = 2;
    localparam int VW = 3 + GW + N + AW + 2 * LW;

    typedef struct {
        int             port;
        bit             wr;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  wdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // round-robin instance
    logic                    rst;
    logic [N-1:0]            req_read, req_write, req_resp;
    logic [N-1:0][AW-1:0]    req_addr;
    logic [N-1:0][LW-1:0]    req_wdata;
    logic [LW-1:0]           req_rdata, mem_wdata, mem_rdata;
    logic                    mem_read, mem_write, mem_resp, busy;
    logic [AW-1:0]           mem_addr;
    logic [GW-1:0]           grant_id;

    mem_arbiter_n #(.NUM_PORTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_MODE(1)) u_dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_resp(req_resp),
        .req_rdata(req_rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .busy(busy), .grant_id(grant_id));

    // fixed-priority instance
    logic                    f_rst;
    logic [N-1:0]            f_rd, f_wr, f_resp;
    logic [N-1:0][AW-1:0]    f_addr;
    logic [N-1:0][LW-1:0]    f_wd;
    logic [LW-1:0]           f_rdata, f_mwdata, f_mrdata;
    logic                    f_mread, f_mwrite, f_mresp, f_busy;
    logic [AW-1:0]           f_maddr;
    logic [GW-1:0]           f_gid;

    mem_arbiter_n #(.NUM_PORTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_MODE(0)) u_fix (
        .clk(clk), .rst(f_rst), .req_read(f_rd), .req_write(f_wr),
        .req_addr(f_addr), .req_wdata(f_wd), .req_resp(f_resp),
        .req_rdata(f_rdata), .mem_read(f_mread), .mem_write(f_mwrite),
        .mem_addr(f_maddr), .mem_wdata(f_mwdata), .mem_rdata(f_mrdata),
        .mem_resp(f_mresp), .busy(f_busy), .grant_id(f_gid));

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: 0 idle, 1 waiting on memory, 2 completing
    int            m_state, m_ptr, m_port, m_lat;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_rdata;
    txn_t          sb[$];
    int            dut_grants[$];
    bit            pend[N];
    int            p_new;
    bit            resp_en, mon_en, fix_done;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction

    task automatic model_edge();
        int w;
        if (rst) begin
            m_state = 0; m_ptr = 0; m_port = 0; m_wr = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
            sb.delete();
        end else if (m_state == 0) begin
            w = -1;
            for (int i = 0; i < N; i++) begin
                int p;
                p = (m_ptr + i) % N;
                if (w < 0 && (req_read[p] || req_write[p])) w = p;
            end
            if (w >= 0) begin
                m_port  = w;
                m_wr    = req_write[w];
                m_addr  = req_addr[w];
                m_wdata = req_wdata[w];
                m_ptr   = (w + 1) % N;
                m_state = 1;
                m_lat   = int'($urandom_range(4));
                sb.push_back('{w, m_wr, m_addr, m_wdata});
            end
        end else if (m_state == 1) begin
            if (mem_resp) begin
                if (!m_wr) m_rdata = line_of(m_addr);
                m_state = 2;
            end
        end else begin
            m_state = 0;
        end
    endtask

    task automatic choose_inputs();
        int op;
        for (int k = 0; k < N; k++) begin
            if (m_state == 2 && m_port == k) begin
                req_read[k] = 1'b0; req_write[k] = 1'b0; pend[k] = 0;
            end else if (!pend[k]) begin
                if (int'($urandom_range(99)) < p_new) begin
                    op = int'($urandom_range(2));
                    req_read[k]  = (op != 1);
                    req_write[k] = (op != 0);
                    req_addr[k]  = $urandom;
                    req_wdata[k] = {$urandom, $urandom};
                    pend[k] = 1;
                end
            end else if (m_state == 1 && m_port == k) begin
                if ($urandom_range(1) == 1) begin
                    req_addr[k]  = $urandom;
                    req_wdata[k] = {$urandom, $urandom};
                end
                if ($urandom_range(9) == 0) begin
                    req_read[k] = 1'b0; req_write[k] = 1'b0; pend[k] = 0;
                end
            end
        end
        mem_resp  = 1'b0;
        mem_rdata = {$urandom, $urandom};
        if (m_state == 1) begin
            if (resp_en) begin
                if (m_lat == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = line_of(mem_addr);
                end else begin
                    m_lat--;
                end
            end
        end else begin
            mem_resp = ($urandom_range(7) == 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        choose_inputs();
    endtask

    // monitor / scoreboard
    logic [N-1:0] e_resp;
    logic [VW-1:0] exp_v, act_v;
    txn_t mon_t;
    always @(negedge clk) begin
        if (mon_en) begin
            e_resp = (m_state == 2) ? (N'(1) << m_port) : '0;
            exp_v = {(m_state != 0), (m_state == 1 && !m_wr), (m_state == 1 && m_wr),
                     GW'(m_port), e_resp, m_addr, m_wdata, m_rdata};
            act_v = {busy, mem_read, mem_write, grant_id, req_resp, mem_addr, mem_wdata, req_rdata};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL outputs t=%0t got %h want %h", $time, act_v, exp_v);
            end
            if (req_resp != '0) begin
                n_cmp++;
                for (int k = 0; k < N; k++) if (req_resp[k]) dut_grants.push_back(k);
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL resp_unexpected t=%0t got resp=%b want none", $time, req_resp);
                end else begin
                    mon_t = sb.pop_front();
                    if (req_resp !== (N'(1) << mon_t.port) ||
                        (!mon_t.wr && req_rdata !== line_of(mon_t.addr))) begin
                        n_err++;
                        $display("FAIL resp t=%0t got resp=%b rdata=%h want port %0d rdata=%h",
                                 $time, req_resp, req_rdata, mon_t.port, line_of(mon_t.addr));
                    end
                end
            end
            if ((mem_read || mem_write) && sb.size() > 0) begin
                n_cmp++;
                if ({mem_write, mem_read, mem_addr, mem_wdata} !==
                    {sb[0].wr, !sb[0].wr, sb[0].addr, sb[0].wdata}) begin
                    n_err++;
                    $display("FAIL payload t=%0t got wr=%b rd=%b a=%h d=%h want wr=%b a=%h d=%h",
                             $time, mem_write, mem_read, mem_addr, mem_wdata,
                             sb[0].wr, sb[0].addr, sb[0].wdata);
                end
            end
        end
    end

    int exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0; p_new = 0; resp_en = 1; mon_en = 0;
        m_state = 0; m_ptr = 0; m_port = 0; m_lat = 0; m_wr = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        for (int k = 0; k < N; k++) pend[k] = 0;
        step();
        mon_en = 1;
        step(); step();
        rst = 1'b0;

        // all ports contending continuously
        p_new = 100;
        repeat (40) step();
        if (dut_grants.size() < 5) begin
            n_cmp++; n_err++;
            $display("FAIL rr_order got %0d grants want at least 5", dut_grants.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (dut_grants[i] != exp_ord[i]) begin
                    n_err++;
                    $display("FAIL rr_order[%0d] got %0d want %0d", i, dut_grants[i], exp_ord[i]);
                end
            end
        end

        p_new = 20;
        repeat (400) step();

        // reset in the middle of a transaction, then a late mem_resp
        p_new = 0;
        req_read = '0; req_write = '0;
        for (int k = 0; k < N; k++) pend[k] = 0;
        for (int i = 0; i < 50 && m_state != 0; i++) step();
        req_read = '0; req_write = '0;
        req_read[1] = 1'b1; pend[1] = 1; resp_en = 0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0; resp_en = 1;
        mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
        req_read = '0; req_write = '0;
        req_read[0] = 1'b1; req_write[3] = 1'b1;
        for (int k = 0; k < N; k++) pend[k] = (k == 0 || k == 3);
        step();
        n_cmp++;
        if (grant_id !== 2'd0 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL rr_after_reset got gid=%0d rd=%b wr=%b want gid=0 rd=1 wr=0",
                     grant_id, mem_read, mem_write);
        end
        p_new = 20;
        repeat (60) step();

        for (int i = 0; i < 200 && !fix_done; i++) @(posedge clk);
        if (!fix_done) begin
            n_cmp++; n_err++;
            $display("FAIL fixed_timeout got unfinished want finished");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // fixed priority: ports 0 and 2 read continuously; port 2 waits until port 0 drops
    initial begin
        int fc, npulse;
        logic [N-1:0] want;
        f_rst = 1'b1; f_rd = '0; f_wr = '0; f_addr = '0; f_wd = '0;
        f_mresp = 1'b0; f_mrdata = 64'h1234_5678_9ABC_DEF0; fix_done = 0;
        fc = 0; npulse = 0;
        repeat (3) @(posedge clk);
        #1;
        f_rst = 1'b0;
        f_rd = 4'b0101;
        f_addr[0] = 32'h0000_0100; f_addr[2] = 32'h0000_0300;
        for (int cyc = 0; cyc < 300 && npulse < 4; cyc++) begin
            @(posedge clk);
            #1;
            if (f_resp != '0) begin
                want = (npulse < 3) ? 4'b0001 : 4'b0100;
                n_cmp++;
                if (f_resp !== want) begin
                    n_err++;
                    $display("FAIL fixed_grant[%0d] got %b want %b", npulse, f_resp, want);
                end
                npulse++;
                if (npulse == 3) f_rd[0] = 1'b0;
            end
            if (f_mread && !f_mresp) begin
                if (fc == 1) begin f_mresp = 1'b1; fc = 0; end
                else fc++;
            end else begin
                f_mresp = 1'b0;
            end
        end
        if (npulse < 4) begin
            n_cmp++; n_err++;
            $display("FAIL fixed_pulses got %0d want 4", npulse);
        end
        fix_done = 1;
    end

endmodule
